// File: rtl/sr_register_bank_pkg.sv
// Shared encodings for sr_register_bank: shift/load mode values and set/clear conflict policies.
package sr_register_bank_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_SHR  = 2'b11
  } srMode_e;

  localparam logic [1:0] CONF_HOLD   = 2'd0;
  localparam logic [1:0] CONF_SET    = 2'd1;
  localparam logic [1:0] CONF_CLR    = 2'd2;
  localparam logic [1:0] CONF_TOGGLE = 2'd3;

  // Out-of-range policy values fall back to hold.
  function automatic logic [1:0] normConflict(input int policy);
    logic [1:0] res;
    if ((policy >= 0) && (policy <= 3)) begin
      res = policy[1:0];
    end else begin
      res = CONF_HOLD;
    end
    return res;
  endfunction

endpackage

// File: rtl/sr_register_bank_bit_resolve.sv
// Per-bit set/clear override of the mode-selected base bit; purely combinational.
module sr_bit_resolve
  import sr_register_bank_pkg::*;
#(
  parameter int CONFLICT = 0
) (
  input  logic baseBit,
  input  logic qBit,
  input  logic setBit,
  input  logic clrBit,
  output logic resBit
);

  localparam logic [1:0] POLICY = normConflict(CONFLICT);

  logic resBit_s;

  // Resolve overrides; a set/clear conflict looks at the current q bit, not the base.
  always_comb begin
    resBit_s = baseBit;
    case ({setBit, clrBit})
      2'b10: resBit_s = 1'b1;
      2'b01: resBit_s = 1'b0;
      2'b11: begin
        case (POLICY)
          CONF_HOLD:   resBit_s = qBit;
          CONF_SET:    resBit_s = 1'b1;
          CONF_CLR:    resBit_s = 1'b0;
          CONF_TOGGLE: resBit_s = ~qBit;
          default:     resBit_s = qBit;
        endcase
      end
      2'b00:   resBit_s = baseBit;
      default: resBit_s = baseBit;
    endcase
  end

  assign resBit = resBit_s;

endmodule

// File: rtl/sr_register_bank.sv
// Clocked WIDTH-bit set/clear register with load and shift modes.
// Optional registered parity output enabled by SR_REGISTER_BANK_PARITY_EN.
module sr_register_bank
  import sr_register_bank_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               CONFLICT  = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             ser_out,
`ifdef SR_REGISTER_BANK_PARITY_EN
  output logic             parity,
`endif
  output logic             changed
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] baseQ_s;
  logic [WIDTH-1:0] resolvedQ_s;
  logic [WIDTH-1:0] nextQ_s;
  logic             changed_r;
  logic             serOut_s;

  // Stage 1: base value chosen by mode; shifts fill only from ser_in.
  always_comb begin
    baseQ_s = q_r;
    case (mode)
      MODE_HOLD: baseQ_s = q_r;
      MODE_LOAD: baseQ_s = d;
      MODE_SHL:  baseQ_s = {q_r[WIDTH-2:0], ser_in};
      MODE_SHR:  baseQ_s = {ser_in, q_r[WIDTH-1:1]};
      default:   baseQ_s = q_r;
    endcase
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : gBit
    sr_bit_resolve #(.CONFLICT(CONFLICT)) uResolve (
      .baseBit(baseQ_s[gi]),
      .qBit   (q_r[gi]),
      .setBit (set[gi]),
      .clrBit (clr[gi]),
      .resBit (resolvedQ_s[gi])
    );
  end

  // Disabled updates keep q as is.
  always_comb begin
    if (en) begin
      nextQ_s = resolvedQ_s;
    end else begin
      nextQ_s = q_r;
    end
  end

  // Register state; reset overrides any pending update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r       <= RESET_VAL;
      changed_r <= 1'b0;
    end else begin
      q_r       <= nextQ_s;
      changed_r <= (nextQ_s != q_r);
    end
  end

  // In shift-right the LSB leaves the register, otherwise the MSB.
  always_comb begin
    if (mode == MODE_SHR) begin
      serOut_s = q_r[0];
    end else begin
      serOut_s = q_r[WIDTH-1];
    end
  end

`ifdef SR_REGISTER_BANK_PARITY_EN
  logic parity_r;

  function automatic logic calcParity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Parity tracks the value q takes at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_r <= calcParity(RESET_VAL);
    end else begin
      parity_r <= calcParity(nextQ_s);
    end
  end

  assign parity = parity_r;
`endif

  assign q       = q_r;
  assign q_n     = ~q_r;
  assign ser_out = serOut_s;
  assign changed = changed_r;

endmodule

// File: tb/tb_sr_register_bank.sv
// Scoreboard bench: five banks (CONFLICT 0..3 and out-of-range 7) share stimulus.
module tb_sr_register_bank;

  localparam int N = 5;

  typedef struct packed {
    logic [N-1:0][3:0] q;
    logic [N-1:0]      chg;
    logic [N-1:0]      ser;
    logic              serChk;
  } exp_t;

  logic       clk = 1'b1;
  logic       rst_n, en, ser_in;
  logic [1:0] mode;
  logic [3:0] d, set, clr;
  logic [3:0] qA   [N];
  logic [3:0] qnA  [N];
  logic       serA [N];
  logic       chgA [N];
`ifdef SR_REGISTER_BANK_PARITY_EN
  logic       parA [N];
`endif

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : gDut
    sr_register_bank #(
      .WIDTH    (4),
      .CONFLICT ((gi == 4) ? 7 : gi),
      .RESET_VAL(4'b1010)
    ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .mode   (mode),
      .d      (d),
      .ser_in (ser_in),
      .set    (set),
      .clr    (clr),
      .q      (qA[gi]),
      .q_n    (qnA[gi]),
      .ser_out(serA[gi]),
`ifdef SR_REGISTER_BANK_PARITY_EN
      .parity (parA[gi]),
`endif
      .changed(chgA[gi])
    );
  end

  task automatic chk(input string name, input int inst, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[conf%0d] got=%b expected=%b t=%0t", name, inst, act, exp, $time);
    end
  endtask

  // Monitor: ser_out checked before the edge, registered outputs after it.
  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        r = sb.pop_front();
        if (r.serChk) begin
          for (int i = 0; i < N; i++) chk("ser_out", i, {3'b000, serA[i]}, {3'b000, r.ser[i]});
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
          chk("q", i, qA[i], r.q[i]);
          chk("q_n", i, qnA[i], ~r.q[i]);
          chk("changed", i, {3'b000, chgA[i]}, {3'b000, r.chg[i]});
`ifdef SR_REGISTER_BANK_PARITY_EN
          chk("parity", i, {3'b000, parA[i]}, {3'b000, ^r.q[i]});
`endif
        end
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic [3:0] dd,
                       input logic si, input logic [3:0] s, input logic [3:0] c);
    rst_n = r; en = e; mode = m; d = dd; ser_in = si; set = s; clr = c;
  endtask

  task automatic expectAll(input logic [3:0] eq, input logic ec, input logic es, input logic sc);
    exp_t r;
    for (int i = 0; i < N; i++) begin
      r.q[i] = eq; r.chg[i] = ec; r.ser[i] = es;
    end
    r.serChk = sc;
    sb.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t r;
    // Reset for two cycles, then hold with en low (inputs ignored).
    drive(1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 4'b0000, 4'b0000); expectAll(4'b1010, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, 4'b0000, 4'b0000); expectAll(4'b1010, 1'b0, 1'b1, 1'b1); tick();
    drive(1'b1, 1'b0, 2'b01, 4'b1111, 1'b0, 4'b1111, 4'b0000); expectAll(4'b1010, 1'b0, 1'b1, 1'b1); tick();
    // Load then shift left.
    drive(1'b1, 1'b1, 2'b01, 4'b0110, 1'b0, 4'b0000, 4'b0000); expectAll(4'b0110, 1'b1, 1'b1, 1'b1); tick();
    drive(1'b1, 1'b1, 2'b10, 4'b0000, 1'b1, 4'b0000, 4'b0000); expectAll(4'b1101, 1'b1, 1'b0, 1'b1); tick();
    // Shift-right drain of all ones.
    drive(1'b1, 1'b1, 2'b01, 4'b1111, 1'b0, 4'b0000, 4'b0000); expectAll(4'b1111, 1'b1, 1'b1, 1'b1); tick();
    drive(1'b1, 1'b1, 2'b11, 4'b0000, 1'b0, 4'b0000, 4'b0000); expectAll(4'b0111, 1'b1, 1'b1, 1'b1); tick();
    drive(1'b1, 1'b1, 2'b11, 4'b0000, 1'b0, 4'b0000, 4'b0000); expectAll(4'b0011, 1'b1, 1'b1, 1'b1); tick();
    drive(1'b1, 1'b1, 2'b11, 4'b0000, 1'b0, 4'b0000, 4'b0000); expectAll(4'b0001, 1'b1, 1'b1, 1'b1); tick();
    drive(1'b1, 1'b1, 2'b11, 4'b0000, 1'b0, 4'b0000, 4'b0000); expectAll(4'b0000, 1'b1, 1'b1, 1'b1); tick();
    // Set/clear override on top of a load, then repeated with no change.
    drive(1'b1, 1'b1, 2'b01, 4'b1000, 1'b0, 4'b0000, 4'b0000); expectAll(4'b1000, 1'b1, 1'b0, 1'b1); tick();
    drive(1'b1, 1'b1, 2'b01, 4'b0000, 1'b0, 4'b0001, 4'b1000); expectAll(4'b0001, 1'b1, 1'b1, 1'b1); tick();
    drive(1'b1, 1'b1, 2'b01, 4'b0000, 1'b0, 4'b0001, 4'b1000); expectAll(4'b0001, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b1, 1'b1, 2'b01, 4'b0101, 1'b0, 4'b0000, 4'b0000); expectAll(4'b0101, 1'b1, 1'b0, 1'b1); tick();
    // Full conflict from q=0101: hold, set, clear, toggle, illegal->hold.
    drive(1'b1, 1'b1, 2'b00, 4'b0000, 1'b0, 4'b1111, 4'b1111);
    r.q[0] = 4'b0101; r.chg[0] = 1'b0;
    r.q[1] = 4'b1111; r.chg[1] = 1'b1;
    r.q[2] = 4'b0000; r.chg[2] = 1'b1;
    r.q[3] = 4'b1010; r.chg[3] = 1'b1;
    r.q[4] = 4'b0101; r.chg[4] = 1'b0;
    r.ser = 5'b00000; r.serChk = 1'b1;
    sb.push_back(r); tick();
    // Reload re-aligns all banks; ser_out before the edge reflects each bank's MSB.
    drive(1'b1, 1'b1, 2'b01, 4'b0011, 1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < N; i++) begin
      r.q[i] = 4'b0011; r.chg[i] = 1'b1;
    end
    r.ser = 5'b01010; r.serChk = 1'b1;
    sb.push_back(r); tick();
    drive(1'b1, 1'b1, 2'b10, 4'b0000, 1'b0, 4'b0000, 4'b0000); expectAll(4'b0110, 1'b1, 1'b0, 1'b1); tick();
    // Reset wins over an enabled load.
    drive(1'b0, 1'b1, 2'b01, 4'b1111, 1'b0, 4'b0000, 4'b0000); expectAll(4'b1010, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b1, 1'b1, 2'b00, 4'b0000, 1'b0, 4'b0000, 4'b0000); expectAll(4'b1010, 1'b0, 1'b1, 1'b1); tick();
    // Set-only on top of a right shift.
    drive(1'b1, 1'b1, 2'b11, 4'b0000, 1'b1, 4'b0001, 4'b0000); expectAll(4'b1101, 1'b1, 1'b0, 1'b1); tick();
    drive(1'b1, 1'b0, 2'b00, 4'b0000, 1'b0, 4'b0000, 4'b0000);
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sr_register_bank.md
Name: sr_register_bank

Overview:
- Parametrised, clocked successor to the 4-bit SR-latch storage cell.
- WIDTH-bit register with synchronous per-bit set/clear, parallel load, and left/right shift modes.
- Configurable set/clear conflict policy.
- Feeds the 4-bit register datapath and any wider score/state registers in the game logic.

Parameters:
- WIDTH, 4, register width in bits (≥2).
- CONFLICT, 0, per-bit policy when set and clear are both high: 0 hold, 1 set wins, 2 clear wins, 3 toggle.
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  update enable; when low, q holds and all other inputs are ignored.
- mode  in  2  00 hold, 01 parallel load, 10 shift left, 11 shift right.
- d  in  WIDTH  parallel load data.
- ser_in  in  1  serial input bit for shifts.
- set  in  WIDTH  per-bit synchronous set.
- clr  in  WIDTH  per-bit synchronous clear.
- q  out  WIDTH  register contents.
- q_n  out  WIDTH  bitwise complement of q.
- ser_out  out  1  bit shifted out.
- changed  out  1  high for one cycle when q took a new value at the last edge.

Behaviour:
- Reset is synchronous and active-low on clk.
  - Priority: rst_n low overrides everything.
  - Reset values: q=RESET_VAL, q_n=~RESET_VAL, changed=0.
- en low: q holds and changed=0 at the next edge.
- en high: next q is computed in two stages, both in the same cycle.
  - Stage 1, base value from mode:
    - hold: q.
    - load: d.
    - shl: {q[WIDTH-2:0], ser_in}.
    - shr: {ser_in, q[WIDTH-1:1]}.
  - Stage 2, per-bit override of the base value:
    - set=1, clr=0: bit forced to 1.
    - set=0, clr=1: bit forced to 0.
    - set=1, clr=1: resolved by CONFLICT. Hold/toggle use the current q bit, not the base value.
    - set=0, clr=0: base bit passes through.
- Latency: one clock from inputs to q; no combinational path from inputs to q.
- q_n is the combinational complement of registered q. It can never equal q.
- ser_out is combinational:
  - mode==11: q[0].
  - otherwise: q[WIDTH-1].
  - In shl, ser_out is the MSB that is lost at the next edge.
- changed is registered: (next_q != q) sampled at the same edge that updates q. It reads 0 after reset, when en is low, and whenever next_q equals q.
- Boundary cases:
  - Shifting all-ones with ser_in=0 reaches zero after WIDTH shifts.
  - Shift does not wrap; ser_in is the only fill source.
  - Reset mid-shift discards the shift.
  - rst_n and en both asserted: reset wins.
  - An illegal CONFLICT value is treated as 0.

Optional Feature:
- Macro: SR_REGISTER_BANK_PARITY_EN.
- Defined: adds output port parity (1 bit).
  - parity = XOR of q, registered and updated together with q.
  - Reset value: XOR of RESET_VAL.
- Undefined: the port is absent; there is no parity logic.

Decomposition:
- Shared package holds:
  - mode encodings MODE_HOLD=2'b00, MODE_LOAD=2'b01, MODE_SHL=2'b10, MODE_SHR=2'b11.
  - conflict policy constants CONF_HOLD, CONF_SET, CONF_CLR, CONF_TOGGLE.
- One natural sub-module, sr_bit_resolve: the combinational per-bit resolution of base bit, q bit, set, clr and CONFLICT. It is instantiated WIDTH times via generate. The top holds the flops, mode mux and changed logic.

Test Plan:
- Reset: rst_n=0 for 2 cycles with WIDTH=4, RESET_VAL=4'b1010 → q=1010, q_n=0101, changed=0. Release, en=0 → q stays 1010, changed=0.
- Load then shift left: en=1, mode=01, d=0110 → q=0110, changed=1. Then mode=10, ser_in=1 → q=1101; ser_out before that edge=0.
- Shift right drain: q=1111, mode=11, ser_in=0 for 4 cycles → q=0111, 0011, 0001, 0000; ser_out=1 each cycle; changed=1 on all 4 edges.
- Override over load: mode=01, d=0000, set=0001, clr=1000 with q=1000 → q=0001. Repeat the same inputs → q stays 0001, changed=0.
- Conflict policy: set=clr=4'b1111, mode=00, q=0101. CONFLICT=0 → 0101; =1 → 1111; =2 → 0000; =3 → 1010.
- Reset priority: rst_n=0 together with en=1, mode=01, d=1111 → q=RESET_VAL. With the parity macro defined, parity tracks XOR of q at every step above.
